instr_queue: RTL and testbench
==============================

Name: instr_queue

Overview:
- Circular FIFO between the fetch stage and decode/rename.
- Accepts one {pc, instruction} entry per cycle from fetch and presents the oldest entry to decode with first-word fall-through.
- Flushes completely on branch mispredict.
- Drives the full flag that fetch uses to stall its PC and push logic.

Parameters:
- DEPTH, 16, number of entries; power of 2, at least 2.
- WIDTH, 64, entry width; layout is {pc[63:32], instr[31:0]}, i.e. 2*INSTR_WIDTH.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- flush  input  1  mispredict flush; empties the queue
- push  input  1  enqueue request from fetch
- push_data  input  WIDTH  entry to enqueue, {pc, instr}
- full  output  1  occupancy == DEPTH
- pop  input  1  dequeue request from decode
- pop_valid  output  1  queue non-empty; pop_data is valid
- pop_data  output  WIDTH  head entry, combinational read of storage at the head pointer
- count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - On the rst edge: head, tail and count clear to 0.
  - Immediately after reset: full=0, pop_valid=0, count=0.
  - pop_data is don't-care while pop_valid=0; storage is not cleared.
- State: head pointer, tail pointer, and an explicit count register. Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Flags:
  - full = (count==DEPTH); pop_valid = (count!=0).
  - Both are pure functions of registered state, with no combinational path from push or pop.
- Accepted push: push && !full.
  - mem[tail] <= push_data; tail <= tail+1.
  - Entry is visible on pop_data the next cycle if the queue was empty.
- Accepted pop: pop && pop_valid.
  - head <= head+1.
  - pop_data is the head entry in the same cycle pop is sampled.
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - both accepted: unchanged. Pointers still advance.
- Full with push and pop in the same cycle: the push is rejected, because full is registered state. Only the pop takes effect and count goes to DEPTH-1. Fetch never pushes while it sees full.
- Empty with push and pop in the same cycle: pop is ignored (pop_valid=0) and the push is accepted. No bypass: pop_data becomes valid next cycle.
- Ignored requests:
  - push while full: no state change, no overwrite.
  - pop while empty: no state change.
- Flush:
  - head <= 0, tail <= 0, count <= 0 on the edge.
  - Flush has priority over a same-cycle push and pop; the push entry is discarded.
  - After the flush edge: pop_valid=0, full=0.
- Priority: rst > flush > push/pop.
- Reset asserted mid-stream discards all entries, identical to flush.
- Simulation-only assertions:
  - push && full
  - pop && !pop_valid
  - count > DEPTH
  - count is X after reset

Optional Feature:
- Macro: INSTR_QUEUE_STATS_EN
- When defined, adds output ports:
  - stat_full_cycles[31:0]: increments every cycle full=1.
  - stat_flushes[31:0]: increments on each flush.
  - stat_max_occ[$clog2(DEPTH):0]: running maximum of count.
- All three stat counters reset to 0 on rst only; flush does not clear them.
- Counters saturate at all-ones.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Reset, then push 0x60000000_00000013 -> next cycle pop_valid=1, pop_data=0x60000000_00000013, count=1. Pop that cycle -> pop_valid=0, count=0.
- Push 16 entries with pc=0x60000000+4i -> after the 16th, full=1 and count=16. A 17th push with data 0xDEAD leaves the queue unchanged. Pops return pc 0x60000000..0x6000003C in order.
- Fill to 16, assert push and pop together -> push rejected, count=15, popped pc=0x60000000. Next cycle full=0.
- Count=5, push and pop every cycle for 40 cycles (pointer wrap) -> count stays 5, output order matches input order, no loss or duplication.
- Count=7, flush together with push of 0x60000100_00000093 -> next cycle count=0, pop_valid=0. A subsequent push of pc 0x60000200 is the next entry popped; the flushed-cycle entry never appears.
- With INSTR_QUEUE_STATS_EN: hold full for 3 cycles, then issue 2 flushes -> stat_full_cycles=3, stat_flushes=2, stat_max_occ=16. rst clears all three to 0.

Source files
------------

// File: rtl/instr_queue_if.sv
// instr_queue_if: fetch-to-decode queue handshake bundle; master is the fetch/decode side, slave is the queue.
interface instr_queue_if #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 64
);
   logic                     flush;
   logic                     push;
   logic [WIDTH-1:0]         push_data;
   logic                     full;
   logic                     pop;
   logic                     pop_valid;
   logic [WIDTH-1:0]         pop_data;
   logic [$clog2(DEPTH):0]   count;
   modport master (output flush, push, push_data, pop, input full, pop_valid, pop_data, count);
   modport slave (input flush, push, push_data, pop, output full, pop_valid, pop_data, count);
endinterface

// File: rtl/instr_queue.sv
// instr_queue: circular first-word-fall-through FIFO of {pc, instr} between fetch and decode, flushed on mispredict.
// Define INSTR_QUEUE_STATS_EN to add the full-cycle, flush and max-occupancy statistics ports.
module instr_queue #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst,
`ifdef INSTR_QUEUE_STATS_EN
   output logic [31:0]            stat_full_cycles,
   output logic [31:0]            stat_flushes,
   output logic [$clog2(DEPTH):0] stat_max_occ,
`endif
   instr_queue_if.slave           q
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;
   // Flags come only from registered count so fetch sees no combinational path from push/pop.
   assign q.full      = count_q == (AW+1)'(DEPTH);
   assign q.pop_valid = count_q != '0;
   assign q.pop_data  = mem[head_q];
   assign q.count     = count_q;
   always_comb begin
      do_push = q.push && !q.full && !q.flush;
      do_pop  = q.pop && q.pop_valid && !q.flush;
      head_d  = q.flush ? '0 : head_q + AW'(do_pop);
      tail_d  = q.flush ? '0 : tail_q + AW'(do_push);
      count_d = q.flush ? '0 : count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
   always_ff @(posedge clk)
      if (do_push && !rst) mem[tail_q] <= q.push_data;
`ifdef INSTR_QUEUE_STATS_EN
   logic [31:0] full_cyc_q, full_cyc_d, flushes_q, flushes_d;
   logic [AW:0] max_occ_q, max_occ_d;
   always_comb begin
      full_cyc_d = (q.full && !(&full_cyc_q)) ? full_cyc_q + 32'd1 : full_cyc_q;
      flushes_d  = (q.flush && !(&flushes_q)) ? flushes_q + 32'd1 : flushes_q;
      max_occ_d  = count_q > max_occ_q ? count_q : max_occ_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         full_cyc_q <= '0;
         flushes_q  <= '0;
         max_occ_q  <= '0;
      end else begin
         full_cyc_q <= full_cyc_d;
         flushes_q  <= flushes_d;
         max_occ_q  <= max_occ_d;
      end
   end
   assign stat_full_cycles = full_cyc_q;
   assign stat_flushes     = flushes_q;
   assign stat_max_occ     = max_occ_q;
`endif
`ifndef SYNTHESIS
   // Fetch and decode are expected to respect the flags; violations are dropped and only reported.
   a_push_full: assert property (@(posedge clk) disable iff (rst) !(q.push && q.full))
      else $warning("instr_queue: push while full ignored");
   a_pop_empty: assert property (@(posedge clk) disable iff (rst) !(q.pop && !q.pop_valid))
      else $warning("instr_queue: pop while empty ignored");
   a_count_range: assert property (@(posedge clk) disable iff (rst) count_q <= (AW+1)'(DEPTH))
      else $error("instr_queue: count exceeds DEPTH");
   a_count_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(count_q))
      else $error("instr_queue: count unknown after reset");
`endif
endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed stimulus with a scoreboard queue; a negedge monitor checks flags and popped entries.
module tb_instr_queue;
   localparam int DEPTH = 16;
   localparam int WIDTH = 64;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   instr_queue_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
`ifdef INSTR_QUEUE_STATS_EN
   logic [31:0] sfc, sfl;
   logic [4:0]  smo;
`endif
   instr_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk(clk),
      .rst(rst),
`ifdef INSTR_QUEUE_STATS_EN
      .stat_full_cycles(sfc),
      .stat_flushes(sfl),
      .stat_max_occ(smo),
`endif
      .q(bus)
   );
   int checks = 0;
   int errors = 0;
   int mcount = 0;
   logic [63:0] exp_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ent(input int pc, input int ins);
      return {32'(pc), 32'(ins)};
   endfunction

   // Monitor: registered flags against the model, and every accepted pop against the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         check("count", 64'(bus.count), 64'(mcount));
         check("full", 64'(bus.full), 64'(mcount == DEPTH));
         check("pop_valid", 64'(bus.pop_valid), 64'(mcount != 0));
         if (bus.pop && bus.pop_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL pop_data: got %h expected nothing", bus.pop_data);
            end else begin
               check("pop_data", bus.pop_data, exp_q.pop_front());
            end
         end
      end
   end

   task automatic cyc(input logic ps, input logic [63:0] d, input logic pp, input logic fl);
      bit ap, apop;
      bus.push = ps;
      bus.push_data = d;
      bus.pop = pp;
      bus.flush = fl;
      ap = ps && mcount < DEPTH;
      apop = pp && mcount > 0;
      if (fl) exp_q.delete();
      else if (ap) exp_q.push_back(d);
      @(posedge clk);
      #1;
      mcount = fl ? 0 : mcount + int'(ap) - int'(apop);
      bus.push = 1'b0;
      bus.pop = 1'b0;
      bus.flush = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.push = 1'b0;
      bus.pop = 1'b0;
      bus.flush = 1'b0;
      bus.push_data = '0;
      exp_q.delete();
      mcount = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic drain();
      while (mcount > 0) cyc(1'b0, '0, 1'b1, 1'b0);
   endtask

   initial begin
      do_reset();
      cyc(1'b0, '0, 1'b0, 1'b0);
      // Single entry round trip.
      cyc(1'b1, 64'h60000000_00000013, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      // Fill, rejected 17th push, ordered drain.
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, ent(32'h60000000 + 4 * i, 32'h13 + i), 1'b0, 1'b0);
      cyc(1'b1, 64'hDEAD, 1'b0, 1'b0);
      drain();
      // Full with push and pop together: push rejected.
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, ent(32'h60000000 + 4 * i, 32'h100 + i), 1'b0, 1'b0);
      cyc(1'b1, 64'hBEEF, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      drain();
      // Steady state at 5 entries with pointer wrap.
      for (int i = 0; i < 5; i++) cyc(1'b1, ent(32'h60000400 + 4 * i, i), 1'b0, 1'b0);
      for (int i = 5; i < 45; i++) cyc(1'b1, ent(32'h60000400 + 4 * i, i), 1'b1, 1'b0);
      drain();
      // Flush wins over a same-cycle push.
      for (int i = 0; i < 7; i++) cyc(1'b1, ent(32'h60000800 + 4 * i, i), 1'b0, 1'b0);
      cyc(1'b1, 64'h60000100_00000093, 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b0);
      cyc(1'b1, 64'h60000200_00000013, 1'b0, 1'b0);
      drain();
      cyc(1'b0, '0, 1'b0, 1'b0);
      // Mid-stream reset behaves like a flush.
      for (int i = 0; i < 3; i++) cyc(1'b1, ent(32'h60000900 + 4 * i, i), 1'b0, 1'b0);
      do_reset();
      cyc(1'b1, 64'h60000A00_00000013, 1'b0, 1'b0);
      drain();
`ifdef INSTR_QUEUE_STATS_EN
      do_reset();
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, ent(32'h60000C00 + 4 * i, i), 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      @(negedge clk);
      check("stat_full_cycles", 64'(sfc), 64'd3);
      check("stat_flushes", 64'(sfl), 64'd2);
      check("stat_max_occ", 64'(smo), 64'd16);
      @(posedge clk);
      #1;
      do_reset();
      @(negedge clk);
      check("stat_full_cycles_rst", 64'(sfc), 64'd0);
      check("stat_flushes_rst", 64'(sfl), 64'd0);
      check("stat_max_occ_rst", 64'(smo), 64'd0);
`endif
      cyc(1'b0, '0, 1'b0, 1'b0);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
